time_set_ctrl: RTL and testbench

User time-setting controller for the 1 Hz time-keeping counter. Turns debounced button pulses into an edit sequence: hour field, then minute field, then commit. Drives the counter's 17-bit time input (hhhhh_mmmmmm_ssssss) and its asynchronous overwrite strobe. Sits between the button debouncers and the counter; its display outputs feed the display driver.

---
 rtl/time_pkg.sv | 38 +++
 rtl/time_set_ctrl_if.sv | 25 ++
 rtl/mod_updown.sv | 25 ++
 rtl/time_set_ctrl.sv | 177 +++++++++++++++++
 tb/tb_time_set_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/time_pkg.sv
// Shared types, constants and helpers for the user time-setting controller.
// Time word layout is hhhhh_mmmmmm_ssssss.
package time_pkg;

    localparam int TIME_W   = 17;
    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int HOUR_MSB = 16;
    localparam int HOUR_LSB = 12;
    localparam int MIN_MSB  = 11;
    localparam int MIN_LSB  = 6;
    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_EDIT_HOUR = 2'd1;
    localparam state_t ST_EDIT_MIN  = 2'd2;
    localparam state_t ST_COMMIT    = 2'd3;

    typedef logic [1:0] field_t;
    localparam field_t FIELD_NONE = 2'b00;
    localparam field_t FIELD_HOUR = 2'b01;
    localparam field_t FIELD_MIN  = 2'b10;

    function automatic int cnt_w(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

    function automatic logic [HOUR_W-1:0] clamp_hour(input logic [HOUR_W-1:0] h);
        return (h > HOUR_W'(HOUR_MAX)) ? 5'd0 : h;
    endfunction

    function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] m);
        return (m > MIN_W'(MIN_MAX)) ? 6'd0 : m;
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button, counter and display signals of the time-setting controller.
// The controller uses the slave view; the button/counter side uses master.
interface time_set_ctrl_if;
    import time_pkg::*;

    logic              btn_mode;
    logic              btn_inc;
    logic              btn_dec;
    logic [TIME_W-1:0] time_cur;
    logic [TIME_W-1:0] time_in;
    logic              time_ow;
    logic              edit_active;
    logic [1:0]        edit_field;
    logic              blink;

    modport master (
        output btn_mode, btn_inc, btn_dec, time_cur,
        input  time_in, time_ow, edit_active, edit_field, blink
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec, time_cur,
        output time_in, time_ow, edit_active, edit_field, blink
    );
endinterface

// File: rtl/mod_updown.sv
// Modulo up/down step: value+1 wraps MAX->0, value-1 wraps 0->MAX.
// Simultaneous inc and dec leave the value unchanged.
module mod_updown #(
    parameter int MAX = 23,
    parameter int W   = 5
) (
    input  logic [W-1:0] value_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] next_o
);
    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] ONE_V  = W'(1);
    localparam logic [W-1:0] ZERO_V = W'(0);

    // wrapped next value
    always_comb begin
        next_o = value_i;
        case ({inc_i, dec_i})
            2'b10:   next_o = (value_i == MAX_V)  ? ZERO_V : value_i + ONE_V;
            2'b01:   next_o = (value_i == ZERO_V) ? MAX_V  : value_i - ONE_V;
            default: next_o = value_i;
        endcase
    end
endmodule

// File: rtl/time_set_ctrl.sv
// User time-setting controller: hour edit, minute edit, then a fixed-length
// overwrite strobe that loads {hour, min, 00} into the 1 Hz time counter.
module time_set_ctrl
    import time_pkg::*;
#(
    parameter int OW_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000_000,
    parameter int BLINK_HALF     = 50_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    time_set_ctrl_if.slave tsc
);
    localparam int OW_W = cnt_w(OW_CYCLES + 1);
    localparam int TO_W = cnt_w(TIMEOUT_CYCLES);
    localparam int BL_W = cnt_w(BLINK_HALF);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);
    localparam logic [OW_W-1:0] OW_LAST = OW_W'(OW_CYCLES);

    state_t              state_q, state_d;
    logic [HOUR_W-1:0]   hour_q, hour_d, hour_nxt_s;
    logic [MIN_W-1:0]    min_q, min_d, min_nxt_s;
    logic [OW_W-1:0]     ow_cnt_q, ow_cnt_d;
    logic [TO_W-1:0]     tmo_q, tmo_d;
    logic [BL_W-1:0]     bl_cnt_q, bl_cnt_d;
    logic                blink_q, blink_d;
    logic                time_ow_q, time_ow_d;
    logic                edit_active_q, edit_active_d;
    field_t              edit_field_q, edit_field_d;
    logic [TIME_W-1:0]   time_in_q, time_in_d;
    logic                any_btn_s, state_chg_s, edit_now_s, edit_next_s;
    logic                unused_sec_s;

    assign any_btn_s    = tsc.btn_mode | tsc.btn_inc | tsc.btn_dec;
    assign state_chg_s  = (state_d != state_q);
    assign edit_now_s   = (state_q == ST_EDIT_HOUR) || (state_q == ST_EDIT_MIN);
    assign edit_next_s  = (state_d == ST_EDIT_HOUR) || (state_d == ST_EDIT_MIN);
    assign unused_sec_s = ^tsc.time_cur[MIN_LSB-1:0];

    mod_updown #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
        .value_i (hour_q),
        .inc_i   (tsc.btn_inc),
        .dec_i   (tsc.btn_dec),
        .next_o  (hour_nxt_s)
    );

    mod_updown #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
        .value_i (min_q),
        .inc_i   (tsc.btn_inc),
        .dec_i   (tsc.btn_dec),
        .next_o  (min_nxt_s)
    );

    // edit FSM; mode outranks inc/dec, any button outranks the timeout
    always_comb begin
        state_d   = state_q;
        hour_d    = hour_q;
        min_d     = min_q;
        ow_cnt_d  = OW_W'(0);
        time_ow_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tsc.btn_mode) begin
                    state_d = ST_EDIT_HOUR;
                    hour_d  = clamp_hour(tsc.time_cur[HOUR_MSB:HOUR_LSB]);
                    min_d   = clamp_min(tsc.time_cur[MIN_MSB:MIN_LSB]);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EDIT_HOUR: begin
                if (tsc.btn_mode) begin
                    state_d = ST_EDIT_MIN;
                end else if (!any_btn_s && (tmo_q == TO_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    hour_d = hour_nxt_s;
                end
            end
            ST_EDIT_MIN: begin
                if (tsc.btn_mode) begin
                    state_d = ST_COMMIT;
                end else if (!any_btn_s && (tmo_q == TO_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    min_d = min_nxt_s;
                end
            end
            ST_COMMIT: begin
                if (ow_cnt_q == OW_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    time_ow_d = 1'b1;
                    ow_cnt_d  = ow_cnt_q + OW_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // idle-timeout counter, cleared by any activity
    always_comb begin
        tmo_d = tmo_q;
        if (state_chg_s || any_btn_s) begin
            tmo_d = TO_W'(0);
        end else if (edit_now_s) begin
            tmo_d = tmo_q + TO_W'(1);
        end else begin
            tmo_d = TO_W'(0);
        end
    end

    // blink phase restarts lit on edit entry and on every inc/dec
    always_comb begin
        blink_d  = blink_q;
        bl_cnt_d = bl_cnt_q;
        if (!edit_next_s) begin
            blink_d  = 1'b0;
            bl_cnt_d = BL_W'(0);
        end else if (state_chg_s || tsc.btn_inc || tsc.btn_dec) begin
            blink_d  = 1'b1;
            bl_cnt_d = BL_W'(0);
        end else if (bl_cnt_q == BL_LAST) begin
            blink_d  = ~blink_q;
            bl_cnt_d = BL_W'(0);
        end else begin
            bl_cnt_d = bl_cnt_q + BL_W'(1);
        end
    end

    // display/load outputs; time_in trails the edit registers by one cycle
    always_comb begin
        time_in_d     = {hour_q, min_q, 6'd0};
        edit_active_d = edit_next_s;
        case (state_d)
            ST_EDIT_HOUR: edit_field_d = FIELD_HOUR;
            ST_EDIT_MIN:  edit_field_d = FIELD_MIN;
            default:      edit_field_d = FIELD_NONE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hour_q        <= 5'd0;
            min_q         <= 6'd0;
            ow_cnt_q      <= OW_W'(0);
            tmo_q         <= TO_W'(0);
            bl_cnt_q      <= BL_W'(0);
            blink_q       <= 1'b0;
            time_ow_q     <= 1'b0;
            edit_active_q <= 1'b0;
            edit_field_q  <= FIELD_NONE;
            time_in_q     <= 17'd0;
        end else begin
            state_q       <= state_d;
            hour_q        <= hour_d;
            min_q         <= min_d;
            ow_cnt_q      <= ow_cnt_d;
            tmo_q         <= tmo_d;
            bl_cnt_q      <= bl_cnt_d;
            blink_q       <= blink_d;
            time_ow_q     <= time_ow_d;
            edit_active_q <= edit_active_d;
            edit_field_q  <= edit_field_d;
            time_in_q     <= time_in_d;
        end
    end

    assign tsc.time_in     = time_in_q;
    assign tsc.time_ow     = time_ow_q;
    assign tsc.edit_active = edit_active_q;
    assign tsc.edit_field  = edit_field_q;
    assign tsc.blink       = blink_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short timing parameters.
module tb_time_set_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic ow_seen;

    time_set_ctrl_if tsc();

    time_set_ctrl #(
        .OW_CYCLES      (3),
        .TIMEOUT_CYCLES (20),
        .BLINK_HALF     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tsc   (tsc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] mk_time(input int h, input int m, input int s);
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
        hh = h[4:0];
        mm = m[5:0];
        ss = s[5:0];
        return {hh, mm, ss};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic i, input logic d);
        tsc.btn_mode = m;
        tsc.btn_inc  = i;
        tsc.btn_dec  = d;
        @(posedge clk);
        #1;
        tsc.btn_mode = 1'b0;
        tsc.btn_inc  = 1'b0;
        tsc.btn_dec  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        tsc.btn_mode = 1'b0;
        tsc.btn_inc  = 1'b0;
        tsc.btn_dec  = 1'b0;
        tsc.time_cur = mk_time(12, 34, 56);
        tick(2);
        chk("rst_time_in", 32'(tsc.time_in), 32'd0);
        chk("rst_time_ow", 32'(tsc.time_ow), 32'd0);
        chk("rst_active",  32'(tsc.edit_active), 32'd0);
        chk("rst_field",   32'(tsc.edit_field), 32'd0);
        chk("rst_blink",   32'(tsc.blink), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // main edit flow 12:34:56 -> 14:33:00
        press(1'b0, 1'b1, 1'b0);
        chk("idle_inc_ignored", 32'(tsc.edit_active), 32'd0);
        press(1'b1, 1'b0, 1'b0);
        chk("enter_hour_active", 32'(tsc.edit_active), 32'd1);
        chk("enter_hour_field",  32'(tsc.edit_field), 32'd1);
        chk("enter_hour_blink",  32'(tsc.blink), 32'd1);
        tick(1);
        chk("capture", 32'(tsc.time_in), 32'(mk_time(12, 34, 0)));
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("enter_min_field", 32'(tsc.edit_field), 32'd2);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        chk("commit_entry_ow",     32'(tsc.time_ow), 32'd0);
        chk("commit_entry_active", 32'(tsc.edit_active), 32'd0);
        chk("commit_entry_tin",    32'(tsc.time_in), 32'(mk_time(14, 33, 0)));
        press(1'b1, 1'b0, 1'b0);
        chk("ow_c1",  32'(tsc.time_ow), 32'd1);
        chk("tin_c1", 32'(tsc.time_in), 32'(mk_time(14, 33, 0)));
        press(1'b0, 1'b1, 1'b0);
        chk("ow_c2",  32'(tsc.time_ow), 32'd1);
        chk("tin_c2", 32'(tsc.time_in), 32'(mk_time(14, 33, 0)));
        press(1'b0, 1'b0, 1'b1);
        chk("ow_c3",  32'(tsc.time_ow), 32'd1);
        chk("tin_c3", 32'(tsc.time_in), 32'(mk_time(14, 33, 0)));
        tick(1);
        chk("ow_fall",      32'(tsc.time_ow), 32'd0);
        chk("ow_fall_tin",  32'(tsc.time_in), 32'(mk_time(14, 33, 0)));
        chk("post_active",  32'(tsc.edit_active), 32'd0);
        tick(1);
        chk("post_ow",  32'(tsc.time_ow), 32'd0);
        chk("post_tin", 32'(tsc.time_in), 32'(mk_time(14, 33, 0)));
        chk("post_field", 32'(tsc.edit_field), 32'd0);

        // wrap boundaries
        tsc.time_cur = mk_time(23, 59, 10);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        tick(1);
        chk("hour_23_inc", 32'(tsc.time_in), 32'(mk_time(0, 59, 0)));
        press(1'b0, 1'b0, 1'b1);
        tick(1);
        chk("hour_0_dec", 32'(tsc.time_in), 32'(mk_time(23, 59, 0)));
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        tick(1);
        chk("min_59_inc", 32'(tsc.time_in), 32'(mk_time(23, 0, 0)));
        press(1'b0, 1'b0, 1'b1);
        tick(1);
        chk("min_0_dec", 32'(tsc.time_in), 32'(mk_time(23, 59, 0)));
        press(1'b1, 1'b0, 1'b0);
        tick(5);
        chk("wrap_exit", 32'(tsc.edit_active), 32'd0);

        // clamp, priority and blink
        tsc.time_cur = mk_time(30, 62, 0);
        press(1'b1, 1'b0, 1'b0);
        tick(1);
        chk("clamp", 32'(tsc.time_in), 32'd0);
        press(1'b0, 1'b1, 1'b0);
        tick(1);
        chk("clamp_inc", 32'(tsc.time_in), 32'(mk_time(1, 0, 0)));
        press(1'b1, 1'b1, 1'b0);
        chk("mode_inc_field", 32'(tsc.edit_field), 32'd2);
        tick(1);
        chk("mode_inc_hour", 32'(tsc.time_in), 32'(mk_time(1, 0, 0)));
        press(1'b0, 1'b1, 1'b1);
        tick(1);
        chk("inc_dec_none", 32'(tsc.time_in), 32'(mk_time(1, 0, 0)));
        press(1'b0, 1'b1, 1'b0);
        chk("blink_inc", 32'(tsc.blink), 32'd1);
        tick(3);
        chk("blink_hold", 32'(tsc.blink), 32'd1);
        tick(1);
        chk("blink_off", 32'(tsc.blink), 32'd0);
        tick(3);
        chk("blink_off_hold", 32'(tsc.blink), 32'd0);
        tick(1);
        chk("blink_on", 32'(tsc.blink), 32'd1);
        tick(2);
        press(1'b0, 1'b1, 1'b0);
        tick(3);
        chk("blink_restart", 32'(tsc.blink), 32'd1);
        tick(1);
        chk("blink_restart_off", 32'(tsc.blink), 32'd0);
        chk("min_after_incs", 32'(tsc.time_in), 32'(mk_time(1, 2, 0)));
        press(1'b1, 1'b0, 1'b0);
        tick(5);

        // timeout from EDIT_HOUR
        tsc.time_cur = mk_time(5, 6, 7);
        press(1'b1, 1'b0, 1'b0);
        ow_seen = 1'b0;
        for (int k = 0; k < 19; k++) begin
            tick(1);
            ow_seen = ow_seen | tsc.time_ow;
        end
        chk("tmo_before", 32'(tsc.edit_active), 32'd1);
        tick(1);
        ow_seen = ow_seen | tsc.time_ow;
        chk("tmo_active", 32'(tsc.edit_active), 32'd0);
        chk("tmo_field",  32'(tsc.edit_field), 32'd0);
        chk("tmo_blink",  32'(tsc.blink), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            ow_seen = ow_seen | tsc.time_ow;
        end
        chk("tmo_no_ow", 32'(ow_seen), 32'd0);

        // reset during the second overwrite cycle
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        tick(1);
        tick(1);
        chk("ow_before_rst", 32'(tsc.time_ow), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_ow",  32'(tsc.time_ow), 32'd0);
        chk("rst_async_tin", 32'(tsc.time_in), 32'd0);
        chk("rst_async_act", 32'(tsc.edit_active), 32'd0);
        chk("rst_async_fld", 32'(tsc.edit_field), 32'd0);
        chk("rst_async_blk", 32'(tsc.blink), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("after_rst_ow", 32'(tsc.time_ow), 32'd0);
        press(1'b0, 1'b1, 1'b0);
        chk("after_rst_idle", 32'(tsc.edit_active), 32'd0);
        press(1'b1, 1'b0, 1'b0);
        chk("after_rst_enter", 32'(tsc.edit_field), 32'd1);
        tick(25);
        chk("final_idle", 32'(tsc.edit_active), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
